// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding, widths and helpers for the BIST controller.
package bist_pkg;

    localparam int SIGNATURE_BITS = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        COMPARE = 3'd5,
        DONE    = 3'd6
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/bist_cycle_counter.sv
// bist_cycle_counter: loadable up-counter with clear and a terminal-count flag that wraps to zero.
module bist_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = count == last;

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable)
            count <= tc ? '0 : count + W'(1);
    end

endmodule

// File: rtl/bist_controller.sv
// bist_controller: sequences one scan BIST session over the TPG, scan chain and signature MISR.
module bist_controller
    import bist_pkg::*;
#(
    parameter int CHAIN_LENGTH = 16,
    parameter int NUM_PATTERNS = 100,
    parameter int PAT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             misr_pass_nfail,
    output logic             scan_enable,
    output logic             capture,
    output logic             tpg_reset,
    output logic             tpg_enable,
    output logic             misr_reset,
    output logic             misr_enable,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass,
    output logic [PAT_W-1:0] pattern_index
);

    localparam int CW = CHAIN_LENGTH > 1 ? clog2(CHAIN_LENGTH) : 1;
    localparam logic [CW-1:0]    SHIFT_LAST = CW'(CHAIN_LENGTH - 1);
    localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);

    state_t        state;
    logic [CW-1:0] shift_cnt;
    logic          shift_tc;
    logic          pat_tc;

    bist_cycle_counter #(.W(CW)) u_shift_cnt (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == INIT || state == CAPTURE),
        .load      (1'b0),
        .load_value('0),
        .enable    (state == SHIFT || state == UNLOAD),
        .last      (SHIFT_LAST),
        .count     (shift_cnt),
        .tc        (shift_tc)
    );

    bist_cycle_counter #(.W(PAT_W)) u_pattern_cnt (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == INIT),
        .load      (1'b0),
        .load_value('0),
        .enable    (state == CAPTURE && !pat_tc),
        .last      (PAT_LAST),
        .count     (pattern_index),
        .tc        (pat_tc)
    );

    // Outputs are registered for the state being entered, so they line up with it exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            scan_enable <= 1'b0;
            capture     <= 1'b0;
            tpg_reset   <= 1'b0;
            tpg_enable  <= 1'b0;
            misr_reset  <= 1'b0;
            misr_enable <= 1'b0;
            bist_busy   <= 1'b0;
            bist_done   <= 1'b0;
            bist_pass   <= 1'b0;
        end else begin
            scan_enable <= 1'b0;
            capture     <= 1'b0;
            tpg_reset   <= 1'b0;
            tpg_enable  <= 1'b0;
            misr_reset  <= 1'b0;
            misr_enable <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= INIT;
                    tpg_reset  <= 1'b1;
                    misr_reset <= 1'b1;
                    bist_busy  <= 1'b1;
                end
                INIT: begin
                    state       <= SHIFT;
                    scan_enable <= 1'b1;
                    tpg_enable  <= 1'b1;
                end
                // The first load compacts nothing; later loads keep the enable they entered with.
                SHIFT: if (shift_tc) begin
                    state   <= CAPTURE;
                    capture <= 1'b1;
                end else begin
                    scan_enable <= 1'b1;
                    tpg_enable  <= 1'b1;
                    misr_enable <= misr_enable;
                end
                CAPTURE: begin
                    state       <= pat_tc ? UNLOAD : SHIFT;
                    scan_enable <= 1'b1;
                    tpg_enable  <= !pat_tc;
                    misr_enable <= 1'b1;
                end
                UNLOAD: if (shift_tc) begin
                    state <= COMPARE;
                end else begin
                    scan_enable <= 1'b1;
                    misr_enable <= 1'b1;
                end
                COMPARE: begin
                    state     <= DONE;
                    bist_pass <= misr_pass_nfail;
                    bist_busy <= 1'b0;
                    bist_done <= 1'b1;
                end
                DONE: if (!start) begin
                    state     <= IDLE;
                    bist_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
Sequences one per-scan BIST session on the scan chain, the pattern generator (TPG) and the 16-bit signature MISR.
- Per session: clears TPG and MISR, applies NUM_PATTERNS shift/capture iterations, unloads the final response, then samples the MISR's golden-signature compare.
- Sits between the test access/top-level start request and the scan datapath.
- Drives scan_enable, the capture strobe, and the MISR/TPG reset and enable lines.

Parameters:
- CHAIN_LENGTH, 16: scan chain length; number of shift cycles per load/unload; must be ≥1.
- NUM_PATTERNS, 100: number of pattern load/capture iterations per session; must be ≥1.
- PAT_W, 16: width of pattern_index output; must satisfy 2^PAT_W > NUM_PATTERNS.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: level request to run a session; sampled in IDLE and DONE.
- misr_pass_nfail, input, 1: MISR signature == golden signature; sampled only in COMPARE.
- scan_enable, output, 1: chain in shift mode.
- capture, output, 1: one-cycle functional capture strobe.
- tpg_reset, output, 1: synchronous clear of the pattern generator.
- tpg_enable, output, 1: advance the pattern generator one bit.
- misr_reset, output, 1: synchronous clear of the MISR.
- misr_enable, output, 1: compact the current scan_out and observation inputs into the MISR.
- bist_busy, output, 1: session in progress (INIT through COMPARE).
- bist_done, output, 1: session complete (DONE state).
- bist_pass, output, 1: latched compare result, valid while bist_done=1.
- pattern_index, output, PAT_W: current pattern number, 0-based.

Behaviour:
- Reset values: all outputs 0, pattern_index 0, state IDLE. Reset wins over every other event in the same cycle.
- Reset mid-session aborts immediately: IDLE next cycle, bist_pass cleared.
- All control outputs are Moore, decoded from registered state and counters. No combinational path from start or misr_pass_nfail to any output.
- IDLE: all control outputs 0. If start=1 → INIT.
- INIT (1 cycle): tpg_reset=1, misr_reset=1, bist_busy=1. Clear shift_cnt and pattern_index. → SHIFT.
- SHIFT (CHAIN_LENGTH cycles): scan_enable=1, tpg_enable=1.
  - misr_enable=1 only when pattern_index>0. Chain contents before the first load are unknown and must not be compacted.
  - shift_cnt counts 0..CHAIN_LENGTH-1; on the last count → CAPTURE.
- CAPTURE (1 cycle): scan_enable=0, capture=1, tpg_enable=0, misr_enable=0.
  - If pattern_index==NUM_PATTERNS-1 → UNLOAD.
  - Otherwise pattern_index+1 → SHIFT.
- UNLOAD (CHAIN_LENGTH cycles): scan_enable=1, misr_enable=1, tpg_enable=0. After the last count → COMPARE.
- COMPARE (1 cycle): all enables 0. Register bist_pass <= misr_pass_nfail. → DONE.
- DONE: bist_done=1, bist_busy=0, bist_pass held.
  - Stays in DONE while start=1; no auto-restart.
  - start=0 → IDLE. bist_pass and pattern_index hold until the next INIT.
- start is ignored while busy; deassertion mid-session does not abort.
- Latency, counted from the first INIT cycle: DONE is entered after 1 + NUM_PATTERNS*(CHAIN_LENGTH+1) + CHAIN_LENGTH + 1 cycles. Defaults: 1718 cycles.
- Per session: misr_enable is high for exactly NUM_PATTERNS*CHAIN_LENGTH cycles; tpg_enable for NUM_PATTERNS*CHAIN_LENGTH cycles.
- At most one of {tpg_reset/misr_reset, capture, scan_enable} is active in any cycle.
- pattern_index never exceeds NUM_PATTERNS-1.
- CHAIN_LENGTH=1 and NUM_PATTERNS=1 must work: SHIFT and UNLOAD each last one cycle.

Decomposition:
- Package bist_pkg:
  - state encoding localparams (IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE; 3 bits);
  - a ceil-log2 function for counter widths;
  - SIGNATURE_BITS=16.
- One natural sub-module, bist_cycle_counter: loadable counter with clear, enable and terminal-count flag. Instantiated twice, once for shift count and once for pattern count.
- The FSM stays in bist_controller.

Test Plan:
1. Reset then start=1 with CHAIN_LENGTH=4, NUM_PATTERNS=3 → INIT 1 cycle; bist_done rises exactly 21 cycles after INIT entry; capture pulses 3 times, 5 cycles apart.
2. Same run, count enables → misr_enable high 12 cycles (0 during the first 4 SHIFT cycles); tpg_enable high 12 cycles; tpg_reset/misr_reset high exactly 1 cycle.
3. misr_pass_nfail=1 only in the COMPARE cycle → bist_pass=1 in DONE. Toggle it to 0 afterwards → bist_pass stays 1. Repeat with 0 in COMPARE → bist_pass=0.
4. Hold start=1 through DONE for 10 cycles → no restart. Drop start → IDLE next cycle. Reassert → INIT; bist_pass cleared only at the next COMPARE.
5. Assert reset in SHIFT of pattern 1 → next cycle all outputs 0, pattern_index 0, bist_pass 0. A fresh start runs the full 21-cycle session.
6. CHAIN_LENGTH=1, NUM_PATTERNS=1 → sequence INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE. Done at cycle 5. misr_enable high only in UNLOAD.
